// File: rtl/spec_frame_ctrl_pkg.sv
// Shared types and constants for the lidar power-spectrum frame sequencer.
package spec_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    WAIT_DATA = 3'd2,
    LOAD      = 3'd3,
    DRAIN     = 3'd4
  } state_e;

  localparam int FFT_LEN_C    = 1024;
  localparam int HALF_LEN_C   = 512;
  localparam int BIN_W_C      = 9;
  localparam int LOAD_W_C     = 10;
  localparam int FIFO_CNT_W_C = 14;

endpackage

// File: rtl/spec_frame_ctrl_if.sv
// Handshake/bus bundle between the frame sequencer and the FIFO/FFT/accumulator.
// Optional TRIG_MISS_CNT_EN adds the missed-trigger counter signal.
interface spec_frame_ctrl_if #(
  parameter int GATE_W = 3
);
  import spec_ctrl_pkg::*;

  logic                          run;
  logic                          trig;
  logic [FIFO_CNT_W_C-1:0]       fifo_cnt;
  logic                          fifo_rd_en;
  logic                          fft_start;
  logic                          ps_valid;
  logic [GATE_W+BIN_W_C-1:0]     acc_addr;
  logic                          acc_we;
  logic                          acc_first;
  logic                          busy;
  logic                          done;
  logic                          trig_miss;
`ifdef TRIG_MISS_CNT_EN
  logic [15:0]                   trig_miss_cnt;
`endif

  modport slave (
    input  run, trig, fifo_cnt, ps_valid,
`ifdef TRIG_MISS_CNT_EN
    output trig_miss_cnt,
`endif
    output fifo_rd_en, fft_start, acc_addr, acc_we, acc_first, busy, done, trig_miss
  );

  modport master (
    output run, trig, fifo_cnt, ps_valid,
`ifdef TRIG_MISS_CNT_EN
    input  trig_miss_cnt,
`endif
    input  fifo_rd_en, fft_start, acc_addr, acc_we, acc_first, busy, done, trig_miss
  );

endinterface

// File: rtl/spec_frame_ctrl_bin_tracker.sv
// Output-side tracker: counts returned power bins per gate and drives the
// accumulator address/strobe one cycle after each valid bin.
module spec_bin_tracker
  import spec_ctrl_pkg::*;
#(
  parameter int N_GATES = 8,
  parameter int GATE_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ps_valid_i,
  input  logic                      active_i,
  input  logic                      first_i,
  output logic [GATE_W+BIN_W_C-1:0] acc_addr_o,
  output logic                      acc_we_o,
  output logic                      acc_first_o,
  output logic                      pulse_complete_o
);

  logic [BIN_W_C-1:0]        bin_q, bin_d;
  logic [GATE_W-1:0]         gate_q, gate_d;
  logic [GATE_W+BIN_W_C-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic                      first_q, first_d;
  logic                      pc_q, pc_d;
  logic                      fire_s;
  logic                      bin_last_s;
  logic                      gate_last_s;

  assign fire_s      = ps_valid_i && active_i;
  assign bin_last_s  = (bin_q == BIN_W_C'(HALF_LEN_C - 1));
  assign gate_last_s = (gate_q == GATE_W'(N_GATES - 1));

  // Bin/gate counters advance only on accepted bins; IDLE traffic is dropped.
  always_comb begin
    bin_d   = bin_q;
    gate_d  = gate_q;
    addr_d  = addr_q;
    first_d = first_q;
    we_d    = fire_s;
    pc_d    = fire_s && bin_last_s && gate_last_s;
    if (fire_s) begin
      addr_d  = {gate_q, bin_q};
      first_d = first_i;
      if (bin_last_s) begin
        bin_d = '0;
        if (gate_last_s) begin
          gate_d = '0;
        end else begin
          gate_d = gate_q + GATE_W'(1);
        end
      end else begin
        bin_d = bin_q + BIN_W_C'(1);
      end
    end else begin
      bin_d = bin_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      gate_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      first_q <= 1'b0;
      pc_q    <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gate_q  <= gate_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      first_q <= first_d;
      pc_q    <= pc_d;
    end
  end

  assign acc_addr_o       = addr_q;
  assign acc_we_o         = we_q;
  assign acc_first_o      = first_q;
  assign pulse_complete_o = pc_q;

endmodule

// File: rtl/spec_frame_ctrl.sv
// Frame sequencer for range-gated lidar spectra: drains N_GATES frames per
// trigger into the FFT and accumulates N_PULSES pulses. Optional: TRIG_MISS_CNT_EN.
module spec_frame_ctrl
  import spec_ctrl_pkg::*;
#(
  parameter int N_GATES  = 8,
  parameter int N_PULSES = 100,
  parameter int GATE_W   = 3,
  parameter int PULSE_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  spec_frame_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [GATE_W-1:0]    in_gate_q, in_gate_d;
  logic [LOAD_W_C-1:0]  load_cnt_q, load_cnt_d;
  logic                 run_q;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 trig_miss_q, trig_miss_d;
  logic                 rd_en_q, rd_en_d;
  logic                 pend_q, pend_d;
  logic                 fft_start_s;
  logic                 run_rise_s;
  logic                 start_s;
  logic                 miss_s;
  logic                 pulse_complete_s;

  assign run_rise_s = bus.run && !run_q;
  assign start_s    = (state_q == IDLE) && run_rise_s;
  assign miss_s     = bus.trig && (state_q != ARMED);

  // Input-side sequencing; pend remembers a pulse completion seen before DRAIN.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    in_gate_d   = in_gate_q;
    load_cnt_d  = load_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fft_start_s = 1'b0;
    pend_d      = pend_q || pulse_complete_s;
    if (miss_s) begin
      trig_miss_d = 1'b1;
    end else begin
      trig_miss_d = trig_miss_q;
    end
    case (state_q)
      IDLE: begin
        if (run_rise_s) begin
          state_d     = ARMED;
          busy_d      = 1'b1;
          pulse_cnt_d = '0;
          trig_miss_d = 1'b0;
          pend_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (bus.trig) begin
          state_d   = WAIT_DATA;
          in_gate_d = '0;
        end else begin
          state_d = ARMED;
        end
      end
      WAIT_DATA: begin
        if (bus.fifo_cnt >= FIFO_CNT_W_C'(FFT_LEN_C)) begin
          state_d     = LOAD;
          fft_start_s = 1'b1;
          load_cnt_d  = '0;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      LOAD: begin
        if (load_cnt_q == LOAD_W_C'(FFT_LEN_C - 1)) begin
          if (in_gate_q < GATE_W'(N_GATES - 1)) begin
            in_gate_d = in_gate_q + GATE_W'(1);
            state_d   = WAIT_DATA;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          load_cnt_d = load_cnt_q + LOAD_W_C'(1);
        end
      end
      DRAIN: begin
        if (pend_q || pulse_complete_s) begin
          pend_d = 1'b0;
          if (pulse_cnt_q < PULSE_W'(N_PULSES - 1)) begin
            pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
            state_d     = ARMED;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    rd_en_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      in_gate_q   <= '0;
      load_cnt_q  <= '0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_miss_q <= 1'b0;
      rd_en_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      in_gate_q   <= in_gate_d;
      load_cnt_q  <= load_cnt_d;
      run_q       <= bus.run;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_miss_q <= trig_miss_d;
      rd_en_q     <= rd_en_d;
      pend_q      <= pend_d;
    end
  end

`ifdef TRIG_MISS_CNT_EN
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating count of ignored triggers, cleared when a run starts.
  always_comb begin
    if (start_s) begin
      miss_cnt_d = 16'h0000;
    end else if (miss_s && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'h0001;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q <= 16'h0000;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.trig_miss_cnt = miss_cnt_q;
`endif

  spec_bin_tracker #(
    .N_GATES (N_GATES),
    .GATE_W  (GATE_W)
  ) u_tracker (
    .clk              (clk),
    .rst              (rst),
    .ps_valid_i       (bus.ps_valid),
    .active_i         (busy_q),
    .first_i          (pulse_cnt_q == '0),
    .acc_addr_o       (bus.acc_addr),
    .acc_we_o         (bus.acc_we),
    .acc_first_o      (bus.acc_first),
    .pulse_complete_o (pulse_complete_s)
  );

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.fft_start  = fft_start_s;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.trig_miss  = trig_miss_q;

endmodule

// File: tb/tb_spec_frame_ctrl.sv
// Scoreboard bench for spec_frame_ctrl with 2 gates and 3 pulses per run.
module tb_spec_frame_ctrl;
  import spec_ctrl_pkg::*;

  localparam int NG = 2;
  localparam int NP = 3;
  localparam int GW = 1;
  localparam int AW = GW + 9;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          first;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   fft_cnt = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  int   fft_stamp[$];

  always #5 clk = ~clk;

  spec_frame_ctrl_if #(.GATE_W(GW)) bus ();

  spec_frame_ctrl #(
    .N_GATES  (NG),
    .N_PULSES (NP),
    .GATE_W   (GW),
    .PULSE_W  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rd(input int target, input int budget);
    int k = 0;
    while (rd_cnt < target && k < budget) begin
      tick();
      k++;
    end
    tick(3);
    check("rd_en_count", rd_cnt, target);
  endtask

  task automatic stream(input logic first);
    exp_t e;
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < 512; b++) begin
        bus.ps_valid = 1'b1;
        e.addr  = AW'(g * 512 + b);
        e.first = first;
        exp_q.push_back(e);
        tick();
        if ((b % 97) == 13) begin
          bus.ps_valid = 1'b0;
          tick();
        end
      end
    end
    bus.ps_valid = 1'b0;
    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Monitor: counts strobes and compares every accumulator write to the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.fft_start) begin
      fft_cnt++;
      fft_stamp.push_back(cyc);
    end
    if (bus.fifo_rd_en) rd_cnt++;
    if (bus.done) done_cnt++;
    if (bus.acc_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL acc_we_unexpected: got write addr %0d expected none", bus.acc_addr);
      end else begin
        e = exp_q.pop_front();
        check("acc_addr", 32'(bus.acc_addr), 32'(e.addr));
        check("acc_first", 32'(bus.acc_first), 32'(e.first));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    bus.run      = 1'b0;
    bus.trig     = 1'b0;
    bus.fifo_cnt = 14'd0;
    bus.ps_valid = 1'b0;
    tick(3);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_trig_miss", bus.trig_miss, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_fft_start", bus.fft_start, 0);
    check("rst_acc_we", bus.acc_we, 0);
    check("rst_acc_addr", 32'(bus.acc_addr), 0);
    check("rst_acc_first", bus.acc_first, 0);
    rst = 1'b0;
    tick(2);

    // Pulse 0 with starvation and a missed trigger during LOAD.
    bus.fifo_cnt = 14'd1000;
    bus.run = 1'b1;
    tick(2);
    check("busy_after_run", bus.busy, 1);
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    tick(20);
    check("starved_no_fft_start", fft_cnt, 0);
    bus.fifo_cnt = 14'd1024;
    tick(3);
    check("fft_start_after_data", fft_cnt, 1);
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    check("trig_miss_in_load", bus.trig_miss, 1);
`ifdef TRIG_MISS_CNT_EN
    check("trig_miss_cnt_one", bus.trig_miss_cnt, 1);
`endif
    wait_rd(2048, 3000);
    check("fft_starts_pulse0", fft_cnt, 2);
    check("fft_start_spacing", fft_stamp[1] - fft_stamp[0], 1025);
    stream(1'b1);
    check("no_done_after_pulse0", done_cnt, 0);
    check("busy_mid_run", bus.busy, 1);

    // Pulses 1 and 2 accumulate with acc_first low.
    for (int p = 1; p < NP; p++) begin
      bus.trig = 1'b1;
      tick();
      bus.trig = 1'b0;
      wait_rd(2048 * (p + 1), 3000);
      stream(1'b0);
    end
    tick(3);
    check("done_once", done_cnt, 1);
    check("busy_cleared", bus.busy, 0);
    check("trig_miss_sticky", bus.trig_miss, 1);
    check("fft_starts_total", fft_cnt, 6);

    // IDLE: bins ignored, trigger flagged, run rising edge clears the flag.
    bus.ps_valid = 1'b1;
    tick(3);
    bus.ps_valid = 1'b0;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    tick(2);
`ifdef TRIG_MISS_CNT_EN
    check("trig_miss_cnt_idle", bus.trig_miss_cnt, 2);
`endif
    check("done_still_once", done_cnt, 1);
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    tick(2);
    check("trig_miss_cleared", bus.trig_miss, 0);
`ifdef TRIG_MISS_CNT_EN
    check("trig_miss_cnt_cleared", bus.trig_miss_cnt, 0);
`endif
    check("busy_new_run", bus.busy, 1);

    // Reset in the middle of LOAD.
    base = rd_cnt;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    for (int k = 0; k < 2000 && rd_cnt < base + 500; k++) tick();
    check("rd_en_before_rst", bus.fifo_rd_en, 1);
    rst = 1'b1;
    #1;
    check("rst_async_rd_en", bus.fifo_rd_en, 0);
    check("rst_async_busy", bus.busy, 0);
    check("rst_async_fft_start", bus.fft_start, 0);
    tick(2);
    rst = 1'b0;
    bus.run = 1'b0;
    tick(2);
    check("idle_after_rst", bus.busy, 0);

    // Fresh run after reset: gate 0 pulse 0 again.
    bus.run = 1'b1;
    tick(2);
    base = rd_cnt;
    fft_cnt = 0;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    wait_rd(base + 2048, 3000);
    check("fresh_fft_starts", fft_cnt, 2);
    stream(1'b1);
    check("fresh_no_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spec_frame_ctrl.md
Name: spec_frame_ctrl

Overview:
- Sequences the 1024-point power-spectrum datapath for range-gated lidar processing.
- On each laser trigger, it drains N_GATES consecutive 1024-sample frames from the ADC sample FIFO into the FFT/power stage.
- It tracks the 512 upper-half power bins that come back for each gate, and generates addresses and write/accumulate strobes for the spectral accumulator RAM.
- It runs N_PULSES pulses per accumulation, then reports completion to the host-side readout.

Parameters:
- FFT_LEN, 1024: samples per frame; power-stage output is FFT_LEN/2 bins per frame.
- N_GATES, 8: range gates (frames) per trigger.
- N_PULSES, 100: triggers accumulated per run.
- GATE_W, 3: width of gate index, clog2(N_GATES).
- PULSE_W, 16: width of pulse counter.

Ports:
- clk  in  1  system clock, 200 MHz.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; rising edge starts an accumulation run.
- trig  in  1  one-cycle laser trigger pulse.
- fifo_cnt  in  14  words currently in sample FIFO.
- fifo_rd_en  out  1  FIFO read strobe; read latency is 1 cycle.
- fft_start  out  1  one-cycle start to power stage.
- ps_valid  in  1  power-spectrum bin valid, upper half bins only.
- acc_addr  out  GATE_W+9  {gate, bin} accumulator address.
- acc_we  out  1  accumulator write strobe.
- acc_first  out  1  high during pulse 0: overwrite instead of add.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when last bin of last pulse is written.
- trig_miss  out  1  sticky: trigger arrived while not in ARMED; cleared by run rising edge.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Input FSM states: IDLE, ARMED, WAIT_DATA, LOAD, DRAIN.
  - IDLE: run rising edge → ARMED. busy←1, pulse_cnt←0, trig_miss←0.
  - ARMED: trig → WAIT_DATA, in_gate←0.
  - WAIT_DATA: fifo_cnt ≥ FFT_LEN → LOAD. fft_start=1 for exactly that transition cycle.
  - LOAD: fifo_rd_en=1 for exactly FFT_LEN cycles, starting the cycle after fft_start, so word 0 lands on xn_index 0. At the end of the count:
    - in_gate<N_GATES-1 → in_gate++, back to WAIT_DATA. The next fft_start follows with no idle cycle if data is present (pipelined FFT).
    - otherwise → DRAIN.
  - DRAIN: waits until the output tracker reports the pulse complete. Then:
    - pulse_cnt<N_PULSES-1 → pulse_cnt++, → ARMED.
    - otherwise → IDLE, busy←0, done=1 for one cycle.
- Output tracker, running independently:
  - Each ps_valid cycle: acc_we=ps_valid registered (1-cycle latency), acc_addr={out_gate, bin}, bin++.
  - bin wraps 511→0 and out_gate++.
  - out_gate wraps N_GATES-1→0 and raises pulse_complete.
  - acc_first = (pulse_cnt==0) sampled with the bin's address.
- trig outside ARMED (including a trig coincident with the DRAIN→ARMED transition cycle) is ignored and sets trig_miss.
- ps_valid while in IDLE: no acc_we; counters untouched.
- run held low mid-run has no effect; only rst aborts a run. rst mid-LOAD drops fifo_rd_en immediately (asynchronous). The FIFO is not flushed by this block.
- fifo_cnt drop below FFT_LEN during LOAD is not checked. The FIFO writer guarantees a full frame exists once fifo_cnt ≥ FFT_LEN.
- N_PULSES=1: acc_first high for all bins; done follows the first pulse.

Optional Feature:
- Macro: TRIG_MISS_CNT_EN.
- Defined: adds output trig_miss_cnt [15:0].
  - Increments on every ignored trigger.
  - Saturates at 0xFFFF.
  - Clears on run rising edge and on rst.
- Undefined: port absent; only the sticky trig_miss flag exists.

Decomposition:
- Package spec_ctrl_pkg holds:
  - state enum (IDLE, ARMED, WAIT_DATA, LOAD, DRAIN);
  - FFT_LEN_C=1024, HALF_LEN_C=512, BIN_W_C=9;
  - the fifo count width.
- One sub-module, spec_bin_tracker. It holds the output-side bin/out_gate counters, acc_addr/acc_we registration and pulse_complete generation. It is instantiated once.

Test Plan:
- Single pulse: N_GATES=2, N_PULSES=1, FIFO preloaded with 2048 words, one trig → two fft_start pulses 1025 cycles apart; 2048 rd_en cycles; ps_valid stream yields 1024 acc_we with addr 0..1023, all with acc_first=1; then done, busy=0.
- Data starvation: fifo_cnt held at 1000 after trig → no fft_start. Raise fifo_cnt to 1024 → fft_start the next cycle, then exactly 1024 rd_en.
- Accumulation: N_PULSES=3 → acc_first=1 only during pulse 0 bins; done exactly once after the 3rd pulse's last bin (addr N_GATES*512-1).
- Missed trigger: second trig during LOAD → trig_miss=1, no extra frame. With TRIG_MISS_CNT_EN, trig_miss_cnt=1. A new run rising edge clears both.
- Reset mid-LOAD: assert rst at rd_en cycle 500 → all outputs 0 immediately, state IDLE. A subsequent run behaves as a fresh start.
